regfile_write_arbiter: RTL and testbench

- Shares the register file's single write port between CPU writeback and game-logic score events.
- CPU writeback gets the port by default. Game score increments are queued in a small FIFO and applied to the score register as read-modify-writes, using an internal shadow of that register.
- A starvation timer forces a one-cycle CPU stall so queued score events cannot wait forever.
- Sits between the pipeline writeback stage, the game FSM and the regfile write inputs.

---
 rtl/regfile_write_arbiter_if.sv | 31 +++
 rtl/regfile_write_arbiter.sv | 113 +++++++++++
 tb/tb_regfile_write_arbiter.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Bundles the writeback, game-event and regfile-write signals around the write-port arbiter.
// The slave modport belongs to the arbiter; master is the view of whoever drives it.
interface regfile_write_arbiter_if #(
  parameter int DEPTH = 4
);
  localparam int CountW = $clog2(DEPTH) + 1;

  logic              cpu_we;
  logic [4:0]        cpu_wreg;
  logic [31:0]       cpu_wdata;
  logic              cpu_stall;
  logic              game_valid;
  logic [2:0]        game_points;
  logic              game_ready;
  logic              game_clear;
  logic              rf_we;
  logic [4:0]        rf_wreg;
  logic [31:0]       rf_wdata;
  logic [31:0]       score;
  logic [CountW-1:0] fifo_count;

  modport slave (
    input  cpu_we, cpu_wreg, cpu_wdata, game_valid, game_points, game_clear,
    output cpu_stall, game_ready, rf_we, rf_wreg, rf_wdata, score, fifo_count
  );

  modport master (
    output cpu_we, cpu_wreg, cpu_wdata, game_valid, game_points, game_clear,
    input  cpu_stall, game_ready, rf_we, rf_wreg, rf_wdata, score, fifo_count
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the regfile write port: CPU writes pass through with zero latency, then a pending score
// clear, then queued score events; game_ready drops only when the event FIFO is full.
module regfile_write_arbiter #(
  parameter int DEPTH     = 4,
  parameter int MAX_WAIT  = 8,
  parameter int SCORE_REG = 29
) (
  input logic                    clock,
  input logic                    ctrl_reset,
  regfile_write_arbiter_if.slave bus
);
  localparam int PtrW  = $clog2(DEPTH);
  localparam int CntW  = $clog2(DEPTH) + 1;
  localparam int WaitW = $clog2(MAX_WAIT + 1);
  localparam logic [CntW-1:0]  FullCount = CntW'(DEPTH);
  localparam logic [WaitW-1:0] WaitLimit = WaitW'(MAX_WAIT - 1);
  localparam logic [4:0]       ScoreReg  = 5'(SCORE_REG);

  logic [2:0]       fifoMem [DEPTH];
  logic [PtrW-1:0]  rdPtr;
  logic [PtrW-1:0]  wrPtr;
  logic [CntW-1:0]  count;
  logic [31:0]      scoreReg;
  logic             clearPending;
  logic [WaitW-1:0] waitCnt;
  logic             stallReg;

  logic        fifoEmpty;
  logic        slotPending;
  logic        gameReady;
  logic        pushOk;
  logic        cpuGrant;
  logic        clearGrant;
  logic        gameGrant;
  logic [31:0] gameSum;

  always_comb begin
    fifoEmpty   = (count == '0);
    slotPending = !fifoEmpty || clearPending;
    gameReady   = (count < FullCount) && !ctrl_reset;
    // An event offered alongside a clear would land in the FIFO being flushed, so drop it.
    pushOk      = bus.game_valid && gameReady && !bus.game_clear;
    cpuGrant    = bus.cpu_we && (bus.cpu_wreg != 5'd0) && !stallReg && !ctrl_reset;
    clearGrant  = !cpuGrant && clearPending;
    gameGrant   = !cpuGrant && !clearPending && !fifoEmpty;
    gameSum     = scoreReg + {29'd0, fifoMem[rdPtr]};

    bus.rf_we    = 1'b0;
    bus.rf_wreg  = 5'd0;
    bus.rf_wdata = 32'd0;
    if (cpuGrant) begin
      bus.rf_we    = 1'b1;
      bus.rf_wreg  = bus.cpu_wreg;
      bus.rf_wdata = bus.cpu_wdata;
    end else if (clearGrant) begin
      bus.rf_we    = 1'b1;
      bus.rf_wreg  = ScoreReg;
    end else if (gameGrant) begin
      bus.rf_we    = 1'b1;
      bus.rf_wreg  = ScoreReg;
      bus.rf_wdata = gameSum;
    end
  end

  always_ff @(posedge clock) begin
    if (pushOk) fifoMem[wrPtr] <= bus.game_points;
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      rdPtr        <= '0;
      wrPtr        <= '0;
      count        <= '0;
      scoreReg     <= '0;
      clearPending <= 1'b0;
      waitCnt      <= '0;
      stallReg     <= 1'b0;
    end else begin
      if (bus.game_clear) begin
        rdPtr <= '0;
        wrPtr <= '0;
        count <= '0;
      end else begin
        if (pushOk)    wrPtr <= wrPtr + PtrW'(1);
        if (gameGrant) rdPtr <= rdPtr + PtrW'(1);
        count <= count + CntW'(pushOk) - CntW'(gameGrant);
      end

      if (bus.game_clear)  clearPending <= 1'b1;
      else if (clearGrant) clearPending <= 1'b0;

      // The shadow follows whatever value actually went to the score register.
      if (clearGrant)                                scoreReg <= 32'd0;
      else if (gameGrant)                            scoreReg <= gameSum;
      else if (cpuGrant && bus.cpu_wreg == ScoreReg) scoreReg <= bus.cpu_wdata;

      stallReg <= 1'b0;
      if (clearGrant || gameGrant || !slotPending) begin
        waitCnt <= '0;
      end else if (waitCnt == WaitLimit) begin
        waitCnt  <= '0;
        stallReg <= 1'b1;
      end else begin
        waitCnt <= waitCnt + WaitW'(1);
      end
    end
  end

  assign bus.game_ready = gameReady;
  assign bus.cpu_stall  = stallReg;
  assign bus.score      = scoreReg;
  assign bus.fifo_count = count;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: a queue-based model predicts each cycle's write
// and status; a negedge monitor pops and compares.
module tb_regfile_write_arbiter;
  localparam int DEPTH     = 4;
  localparam int MAX_WAIT  = 8;
  localparam int SCORE_REG = 29;

  logic clock = 1'b0;
  logic ctrl_reset;
  always #5 clock = ~clock;

  regfile_write_arbiter_if #(.DEPTH(DEPTH)) bus();

  regfile_write_arbiter #(
    .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT), .SCORE_REG(SCORE_REG)
  ) dut (
    .clock(clock),
    .ctrl_reset(ctrl_reset),
    .bus(bus)
  );

  typedef struct {
    logic [4:0]  wreg;
    logic [31:0] wdata;
  } wr_t;

  typedef struct {
    bit          we;
    bit          stall;
    bit          ready;
    int          count;
    logic [31:0] score;
  } st_t;

  wr_t wrQ[$];
  st_t stQ[$];
  int  checks = 0;
  int  failures = 0;
  bit  monOn = 1'b0;

  // Reference model state: pending events as a plain queue of point values.
  int unsigned evQ[$];
  logic [31:0] mScore;
  bit          mClear;
  int          mStarve;
  bit          mStall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    evQ.delete();
    wrQ.delete();
    stQ.delete();
    mScore  = 32'd0;
    mClear  = 1'b0;
    mStarve = 0;
    mStall  = 1'b0;
  endtask

  task automatic cycle(input bit we, input logic [4:0] wreg, input logic [31:0] wdata,
                       input bit gv, input logic [2:0] gp, input bit gc);
    st_t s;
    wr_t w;
    bit  cpuOk;
    bit  pend;
    bit  slot;
    @(posedge clock);
    #1;
    bus.cpu_we      = we;
    bus.cpu_wreg    = wreg;
    bus.cpu_wdata   = wdata;
    bus.game_valid  = gv;
    bus.game_points = gp;
    bus.game_clear  = gc;

    cpuOk   = we && (wreg != 5'd0) && !mStall;
    pend    = mClear || (evQ.size() > 0);
    slot    = !cpuOk && pend;
    s.stall = mStall;
    s.ready = (evQ.size() < DEPTH);
    s.count = evQ.size();
    s.score = mScore;
    s.we    = cpuOk || pend;
    if (cpuOk) begin
      w.wreg  = wreg;
      w.wdata = wdata;
    end else if (mClear) begin
      w.wreg  = 5'(SCORE_REG);
      w.wdata = 32'd0;
    end else begin
      w.wreg  = 5'(SCORE_REG);
      w.wdata = (evQ.size() > 0) ? mScore + evQ[0] : 32'd0;
    end
    if (s.we) wrQ.push_back(w);
    stQ.push_back(s);

    if (slot) begin
      if (mClear) begin
        mClear = 1'b0;
        mScore = 32'd0;
      end else begin
        mScore = mScore + evQ.pop_front();
      end
    end else if (cpuOk && wreg == 5'(SCORE_REG)) begin
      mScore = wdata;
    end
    if (gc) begin
      mClear = 1'b1;
      evQ.delete();
    end else if (gv && s.ready) begin
      evQ.push_back(int'(gp));
    end

    mStall = 1'b0;
    if (slot || !pend) begin
      mStarve = 0;
    end else begin
      mStarve++;
      if (mStarve == MAX_WAIT) begin
        mStall  = 1'b1;
        mStarve = 0;
      end
    end
    monOn = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 3'd0, 1'b0);
  endtask

  always @(negedge clock) begin : monitor
    st_t s;
    wr_t w;
    if (monOn && !ctrl_reset) begin
      if (stQ.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL status_queue: empty, expected an entry at %0t", $time);
      end else begin
        s = stQ.pop_front();
        chk("rf_we", bus.rf_we, s.we);
        chk("cpu_stall", bus.cpu_stall, s.stall);
        chk("game_ready", bus.game_ready, s.ready);
        chk("fifo_count", bus.fifo_count, s.count);
        chk("score", bus.score, s.score);
        if (s.we) begin
          if (wrQ.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL write_queue: empty, expected a write at %0t", $time);
          end else begin
            w = wrQ.pop_front();
            chk("rf_wreg", bus.rf_wreg, w.wreg);
            chk("rf_wdata", bus.rf_wdata, w.wdata);
          end
        end else begin
          chk("idle_wreg", bus.rf_wreg, 32'd0);
          chk("idle_wdata", bus.rf_wdata, 32'd0);
        end
      end
    end
  end

  int stalls;
  int firstStall;

  initial begin
    ctrl_reset      = 1'b1;
    bus.cpu_we      = 1'b0;
    bus.cpu_wreg    = 5'd0;
    bus.cpu_wdata   = 32'd0;
    bus.game_valid  = 1'b0;
    bus.game_points = 3'd0;
    bus.game_clear  = 1'b0;
    modelReset();
    repeat (2) @(posedge clock);
    #1;
    chk("reset_rf_we", bus.rf_we, 32'd0);
    chk("reset_ready", bus.game_ready, 32'd0);
    chk("reset_count", bus.fifo_count, 32'd0);
    ctrl_reset = 1'b0;
    #1;
    chk("idle_ready", bus.game_ready, 32'd1);
    chk("idle_score", bus.score, 32'd0);
    chk("idle_stall", bus.cpu_stall, 32'd0);
    chk("idle_rf_we", bus.rf_we, 32'd0);

    // CPU alone, then register 0 which must never be forwarded.
    cycle(1'b1, 5'd5, 32'hDEAD, 1'b0, 3'd0, 1'b0);
    #1;
    chk("cpu_pass_we", bus.rf_we, 32'd1);
    chk("cpu_pass_wreg", bus.rf_wreg, 32'd5);
    chk("cpu_pass_wdata", bus.rf_wdata, 32'hDEAD);
    cycle(1'b1, 5'd0, 32'h1234, 1'b0, 3'd0, 1'b0);
    #1;
    chk("cpu_r0_we", bus.rf_we, 32'd0);

    // Score accumulation.
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 3'd3, 1'b0);
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 3'd7, 1'b0);
    idle(2);
    chk("acc_score", bus.score, 32'd10);
    chk("acc_count", bus.fifo_count, 32'd0);

    // Fill and starve with the CPU holding the port; score snooped back to 0 first.
    cycle(1'b1, 5'(SCORE_REG), 32'd0, 1'b0, 3'd0, 1'b0);
    stalls = 0;
    firstStall = -1;
    for (int i = 0; i < 25; i++) begin
      cycle(1'b1, 5'd5, 32'h55, (i < 5), 3'd1, 1'b0);
      if (i == 4) begin
        #1;
        chk("full_ready", bus.game_ready, 32'd0);
      end
      if (bus.cpu_stall) begin
        stalls++;
        if (firstStall < 0) begin
          firstStall = i;
          #1;
          chk("stall_wreg", bus.rf_wreg, 32'(SCORE_REG));
          chk("stall_wdata", bus.rf_wdata, 32'd1);
        end
      end
    end
    chk("stall_count", stalls, 32'd2);
    chk("first_stall", firstStall, 32'd9);
    idle(4);
    chk("fill_score", bus.score, 32'd4);

    // Snoop then clear with events queued; the push offered with the clear is discarded.
    cycle(1'b1, 5'(SCORE_REG), 32'd100, 1'b0, 3'd0, 1'b0);
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 3'd2, 1'b0);
    idle(2);
    chk("snoop_score", bus.score, 32'd102);
    for (int i = 0; i < 3; i++) cycle(1'b1, 5'd5, 32'd7, 1'b1, 3'(i + 1), 1'b0);
    cycle(1'b1, 5'd5, 32'd7, 1'b1, 3'd5, 1'b1);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 3'd0, 1'b0);
    #1;
    chk("clear_count", bus.fifo_count, 32'd0);
    chk("clear_wreg", bus.rf_wreg, 32'(SCORE_REG));
    chk("clear_wdata", bus.rf_wdata, 32'd0);
    idle(1);
    chk("clear_score", bus.score, 32'd0);

    // Asynchronous reset between edges with three events queued.
    for (int i = 0; i < 3; i++) cycle(1'b1, 5'd5, 32'd9, 1'b1, 3'd3, 1'b0);
    cycle(1'b1, 5'd5, 32'd9, 1'b0, 3'd0, 1'b0);
    @(negedge clock);
    #1;
    chk("pre_reset_count", bus.fifo_count, 32'd3);
    monOn = 1'b0;
    ctrl_reset = 1'b1;
    #1;
    chk("mid_reset_rf_we", bus.rf_we, 32'd0);
    chk("mid_reset_count", bus.fifo_count, 32'd0);
    chk("mid_reset_ready", bus.game_ready, 32'd0);
    modelReset();
    bus.cpu_we     = 1'b0;
    bus.game_valid = 1'b0;
    @(posedge clock);
    #1;
    ctrl_reset = 1'b0;
    idle(12);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      logic [4:0] wr;
      int         r;
      r  = $urandom_range(0, 7);
      wr = (r == 0) ? 5'd0 : (r == 1) ? 5'(SCORE_REG) : 5'($urandom_range(1, 31));
      cycle(($urandom_range(0, 3) != 0), wr, $urandom, 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)), ($urandom_range(0, 15) == 0));
    end
    idle(20);

    @(posedge clock);
    #1;
    monOn = 1'b0;
    chk("write_queue_drained", wrQ.size(), 32'd0);
    chk("status_queue_drained", stQ.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
